load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  CPU-side initiator for the byte-wide, big-endian data memory port.
//  Accepts one load/store request (byte, half or word) from the datapath.
//  Sequences it as one memory byte per cycle and returns extended load data with a done pulse.
//  Sits between the EX/MEM stage and the data memory; stalls the core via busy.
// PARAMETERS
//  ADDR_W  8  byte-address width; all address arithmetic is modulo 2^ADDR_W
//  RD_LAT  1  data-memory read latency in cycles (legal 1..3)
// PORTS
//  clock      in   1       rising-edge clock
//  reset      in   1       synchronous, active-high reset
//  req        in   1       request strobe; accepted only when busy=0
//  write      in   1       1=store, 0=load
//  size       in   2       00 byte, 01 half, 10 word, 11 treated as word
//  sign_ext   in   1       loads: 1 sign-extend, 0 zero-extend
//  addr       in   ADDR_W  byte address of MSB (big-endian)
//  wdata      in   32      right-justified store data
//  rdata      out  32      extended load result
//  done       out  1       one-cycle completion pulse
//  busy       out  1       request in flight
//  err        out  1       misalignment pulse (ALIGN_CHECK_EN only, else 0)
//  mem_addr   out  ADDR_W  memory byte address
//  mem_wdata  out  8       memory write byte
//  mem_we     out  1       memory write enable
//  mem_re     out  1       memory read enable
//  mem_rdata  in   8       read byte, valid RD_LAT cycles after mem_re
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE. Reset mid-operation aborts; mem_we/mem_re are 0 the next cycle; no done.
//  - N = 1/2/4 bytes for byte/half/word. Accept when req & !busy at edge E0; inputs latched there.
//  - Cycle k after E0 (k=0..N-1): mem_addr=addr+k (wraps), mem_we or mem_re=1; busy=1 from cycle 0.
//  - Store byte order: byte uses wdata[7:0]; half uses [15:8],[7:0]; word uses [31:24]..[7:0] at addr..addr+3.
//  - Load: reads are pipelined, one issue per cycle; byte k is captured at end of cycle k+RD_LAT.
//    First captured byte is most significant. Result zero- or sign-extended from bit 8*N-1.
//  - Timing: store done=1 in cycle N; load done=1 and rdata updated in cycle N+RD_LAT.
//    busy=0 in the done cycle, so a req in that cycle is accepted.
//  - rdata holds until the next load completes; stores never change rdata.
//  - req while busy is ignored (not queued). mem_wdata=0 whenever mem_we=0.
//  - FSM: IDLE -req-> ISSUE (N cycles) -> store: FINISH | load: DRAIN (RD_LAT cycles) -> FINISH (done) -> IDLE.
//    FINISH overlaps IDLE: busy=0, so a req there goes straight to ISSUE.
// CONFIGURATION
//  ALIGN_CHECK_EN defined:
//    Misaligned request (half with addr[0]=1, word with addr[1:0]!=0) issues no memory cycle.
//    done=1 and err=1 in the cycle after E0; rdata unchanged.
//  ALIGN_CHECK_EN undefined: err tied 0; misaligned accesses run byte-serially with address wrap.
// TESTING
//  - Store word 0xDEADBEEF at 0x04 -> bytes DE,AD,BE,EF written to 0x04..0x07 in cycles 0..3; done in cycle 4.
//  - Load word 0x08, memory holds 22 22 22 22, RD_LAT=1 -> rdata=0x22222222, done in cycle 5.
//  - Load byte at 0x24 (value 0x99): sign_ext=1 -> 0xFFFFFF99; sign_ext=0 -> 0x00000099.
//  - Half store 0xA1B2 at 0xFF (no ALIGN_CHECK_EN) -> A1 at 0xFF, B2 at 0x00; err stays 0.
//  - Reset asserted after 2 bytes of a word store -> mem_we=0 next cycle; bytes 2-3 unwritten; busy=0; done never pulses.
//  - ALIGN_CHECK_EN: load word at 0x05 -> no mem_re; done=err=1 one cycle after accept.
//  - Second req while busy -> ignored.
//  - Back-to-back: req held high across a done -> new request starts the next cycle.

Source files
------------

// File: rtl/load_store_unit.sv
// Byte-serial, big-endian load/store sequencer between the EX/MEM stage and data memory.
// Optional ALIGN_CHECK_EN: reject misaligned half/word requests with a done+err pulse.
module load_store_unit #(
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req,
    input  logic              write,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              done,
    output logic              busy,
    output logic              err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [7:0]        mem_rdata
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ISSUE  = 2'd1;
    localparam logic [1:0] DRAIN  = 2'd2;
    localparam logic [1:0] FINISH = 2'd3;

    logic [1:0]        state;
    logic [1:0]        cnt;
    logic [1:0]        last_r;
    logic [1:0]        dcnt;
    logic [ADDR_W-1:0] addr_r;
    logic [31:0]       wsh;
    logic              write_r;
    logic              sign_r;
    logic [RD_LAT-1:0] re_d;
    logic [31:0]       acc;

    logic [1:0]        last_in;
    logic [31:0]       wsh_in;
    logic [31:0]       acc_n;
    logic [31:0]       rdata_n;
    logic              misaligned;
    logic              accept;

    assign last_in = (size == 2'b00) ? 2'd0 : (size == 2'b01) ? 2'd1 : 2'd3;
    assign accept  = req && !busy;

    // Store data is left-justified so the next byte to send is always wsh[31:24].
    always_comb begin
        wsh_in = wdata;
        case (last_in)
            2'd0:    wsh_in = {wdata[7:0], 24'h000000};
            2'd1:    wsh_in = {wdata[15:0], 16'h0000};
            default: wsh_in = wdata;
        endcase
    end

`ifdef ALIGN_CHECK_EN
    logic err_f;
    assign misaligned = ((size == 2'b01) && addr[0]) || (size[1] && (addr[1:0] != 2'b00));
    assign err        = (state == FINISH) && err_f;
`else
    assign misaligned = 1'b0;
    assign err        = 1'b0;
`endif

    assign acc_n = {acc[23:0], mem_rdata};

    always_comb begin
        rdata_n = acc_n;
        case (last_r)
            2'd0:    rdata_n = {{24{sign_r & acc_n[7]}}, acc_n[7:0]};
            2'd1:    rdata_n = {{16{sign_r & acc_n[15]}}, acc_n[15:0]};
            default: rdata_n = acc_n;
        endcase
    end

    assign busy      = (state == ISSUE) || (state == DRAIN);
    assign done      = (state == FINISH);
    assign mem_we    = (state == ISSUE) && write_r;
    assign mem_re    = (state == ISSUE) && !write_r;
    assign mem_addr  = (state == ISSUE) ? addr_r : '0;
    assign mem_wdata = mem_we ? wsh[31:24] : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            last_r  <= '0;
            dcnt    <= '0;
            addr_r  <= '0;
            wsh     <= '0;
            write_r <= 1'b0;
            sign_r  <= 1'b0;
            re_d    <= '0;
            acc     <= '0;
            rdata   <= '0;
`ifdef ALIGN_CHECK_EN
            err_f   <= 1'b0;
`endif
        end else begin
            // Read issue is tracked through a delay line matching the memory latency.
            re_d[0] <= mem_re;
            for (int unsigned i = 1; i < RD_LAT; i++) re_d[i] <= re_d[i-1];
            if (re_d[RD_LAT-1]) acc <= acc_n;
`ifdef ALIGN_CHECK_EN
            err_f <= 1'b0;
`endif
            case (state)
                IDLE, FINISH: begin
                    state <= IDLE;
                    if (accept) begin
                        addr_r  <= addr;
                        wsh     <= wsh_in;
                        write_r <= write;
                        sign_r  <= sign_ext;
                        last_r  <= last_in;
                        cnt     <= '0;
                        if (misaligned) begin
                            state <= FINISH;
`ifdef ALIGN_CHECK_EN
                            err_f <= 1'b1;
`endif
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    addr_r <= addr_r + 1'b1;
                    wsh    <= {wsh[23:0], 8'h00};
                    cnt    <= cnt + 2'd1;
                    dcnt   <= '0;
                    if (cnt == last_r) state <= write_r ? FINISH : DRAIN;
                end
                DRAIN: begin
                    dcnt <= dcnt + 2'd1;
                    if (dcnt == 2'(RD_LAT - 1)) begin
                        state <= FINISH;
                        rdata <= rdata_n;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: byte-wide memory model plus write/load scoreboards.
module tb_load_store_unit;

    localparam int ADDR_W = 8;
    localparam int RD_LAT = 1;

    logic        clock = 1'b0;
    logic        reset;
    logic        req;
    logic        write;
    logic [1:0]  size;
    logic        sign_ext;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        done;
    logic        busy;
    logic        err;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [7:0]  mem_rdata;

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;

    wr_t         wq[$];
    logic [31:0] rq[$];
    logic [31:0] rdata_exp;
    int          n_cmp = 0;
    int          n_err = 0;

    logic [7:0]  mem [256] = '{default: 8'h00};
    logic [7:0]  rd_pipe [RD_LAT] = '{default: 8'h00};

    load_store_unit #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
        .clock(clock), .reset(reset), .req(req), .write(write), .size(size),
        .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .rdata(rdata),
        .done(done), .busy(busy), .err(err), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        rd_pipe[0] <= mem_re ? mem[mem_addr] : 8'h00;
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[RD_LAT-1];

    // Drives one request and monitors it through its done pulse.
    task automatic run_op(input string name, input logic wr, input logic [1:0] sz, input logic sx,
                          input logic [7:0] a, input logic [31:0] wd, input logic [31:0] exp_load,
                          input logic exp_err, input bit keep_req, input bit poke);
        int n, dc, nre, nwe;
        bit seen;
        logic [7:0] ta, td;
        wr_t w;
        n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        dc = exp_err ? 0 : (wr ? n : n + RD_LAT);
        nre = 0; nwe = 0; seen = 0;
        req = 1'b1; write = wr; size = sz; sign_ext = sx; addr = a; wdata = wd;
        if (!exp_err) begin
            if (wr) begin
                for (int k = 0; k < n; k++) begin
                    ta = a + 8'(k);
                    td = 8'(wd >> (8 * (n - 1 - k)));
                    wq.push_back('{a: ta, d: td});
                end
            end else begin
                rq.push_back(exp_load);
            end
        end
        for (int cyc = 0; cyc < 40 && !seen; cyc++) begin
            @(negedge clock);
            n_cmp++;
            if (busy !== (cyc < dc)) begin
                n_err++;
                $display("FAIL %s busy cyc%0d got %b want %b", name, cyc, busy, (cyc < dc));
            end
            if (mem_we) begin
                nwe++;
                n_cmp++;
                if (wq.size() == 0) begin
                    n_err++;
                    $display("FAIL %s extra_write got %h@%h want none", name, mem_wdata, mem_addr);
                end else begin
                    w = wq.pop_front();
                    if (mem_addr !== w.a || mem_wdata !== w.d) begin
                        n_err++;
                        $display("FAIL %s write got %h@%h want %h@%h", name, mem_wdata, mem_addr, w.d, w.a);
                    end
                end
            end else begin
                n_cmp++;
                if (mem_wdata !== 8'h00) begin
                    n_err++;
                    $display("FAIL %s wdata_idle got %h want 00", name, mem_wdata);
                end
            end
            if (mem_re) begin
                ta = a + 8'(nre);
                n_cmp++;
                if (mem_addr !== ta) begin
                    n_err++;
                    $display("FAIL %s read_addr got %h want %h", name, mem_addr, ta);
                end
                nre++;
            end
            if (done) begin
                seen = 1;
                if (!wr && !exp_err && rq.size() > 0) rdata_exp = rq.pop_front();
                n_cmp++;
                if (cyc !== dc) begin
                    n_err++;
                    $display("FAIL %s done_cycle got %0d want %0d", name, cyc, dc);
                end
                n_cmp++;
                if (err !== exp_err) begin
                    n_err++;
                    $display("FAIL %s err got %b want %b", name, err, exp_err);
                end
                n_cmp++;
                if (rdata !== rdata_exp) begin
                    n_err++;
                    $display("FAIL %s rdata got %h want %h", name, rdata, rdata_exp);
                end
            end
            if (poke && cyc == 1) begin
                req = 1'b1; write = 1'b1; size = 2'b10; addr = 8'h80; wdata = 32'hFFFFFFFF;
            end
            if ((cyc == 0 && !keep_req) || (poke && cyc == 2)) req = 1'b0;
        end
        n_cmp++;
        if (!seen) begin
            n_err++;
            $display("FAIL %s timeout got no done want done by cycle %0d", name, dc);
        end
        n_cmp++;
        if (nre !== ((wr || exp_err) ? 0 : n) || nwe !== ((wr && !exp_err) ? n : 0)) begin
            n_err++;
            $display("FAIL %s mem_cycles got re=%0d we=%0d want re=%0d we=%0d", name, nre, nwe,
                     (wr || exp_err) ? 0 : n, (wr && !exp_err) ? n : 0);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; req = 1'b0; write = 1'b0; size = 2'b00; sign_ext = 1'b0;
        addr = 8'h00; wdata = 32'h0;
        rdata_exp = 32'h0;
        repeat (3) @(negedge clock);
        n_cmp++;
        if ({rdata, done, busy, err, mem_addr, mem_wdata, mem_we, mem_re} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs got rdata=%h done=%b busy=%b err=%b ma=%h mw=%h we=%b re=%b want all 0",
                     rdata, done, busy, err, mem_addr, mem_wdata, mem_we, mem_re);
        end
        reset = 1'b0;
    endtask

    task automatic test_store_word();
        run_op("store_word", 1'b1, 2'b10, 1'b0, 8'h04, 32'hDEADBEEF, '0, 1'b0, 0, 0);
        n_cmp++;
        if ({mem[4], mem[5], mem[6], mem[7]} !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL store_word_mem got %h%h%h%h want deadbeef", mem[4], mem[5], mem[6], mem[7]);
        end
    endtask

    task automatic test_load_word();
        run_op("fill_22", 1'b1, 2'b10, 1'b0, 8'h08, 32'h22222222, '0, 1'b0, 0, 0);
        run_op("load_word", 1'b0, 2'b10, 1'b0, 8'h08, '0, 32'h22222222, 1'b0, 0, 0);
    endtask

    task automatic test_load_byte_ext();
        run_op("fill_99", 1'b1, 2'b00, 1'b0, 8'h24, 32'h12345699, '0, 1'b0, 0, 0);
        run_op("load_byte_sx", 1'b0, 2'b00, 1'b1, 8'h24, '0, 32'hFFFFFF99, 1'b0, 0, 0);
        run_op("load_byte_zx", 1'b0, 2'b00, 1'b0, 8'h24, '0, 32'h00000099, 1'b0, 0, 0);
    endtask

    task automatic test_load_half_word3();
        run_op("fill_half", 1'b1, 2'b01, 1'b0, 8'h30, 32'hFFFF8102, '0, 1'b0, 0, 0);
        run_op("load_half_sx", 1'b0, 2'b01, 1'b1, 8'h30, '0, 32'hFFFF8102, 1'b0, 0, 0);
        run_op("load_half_zx", 1'b0, 2'b01, 1'b0, 8'h30, '0, 32'h00008102, 1'b0, 0, 0);
        run_op("fill_size3", 1'b1, 2'b11, 1'b0, 8'h34, 32'h80010203, '0, 1'b0, 0, 0);
        run_op("load_size3", 1'b0, 2'b11, 1'b1, 8'h34, '0, 32'h80010203, 1'b0, 0, 0);
    endtask

    task automatic test_misaligned();
`ifdef ALIGN_CHECK_EN
        run_op("mis_store_half", 1'b1, 2'b01, 1'b0, 8'hFF, 32'h0000A1B2, '0, 1'b1, 0, 0);
        n_cmp++;
        if (mem[255] !== 8'h00) begin
            n_err++;
            $display("FAIL mis_store_mem got %h want 00", mem[255]);
        end
        run_op("mis_load_word", 1'b0, 2'b10, 1'b0, 8'h05, '0, '0, 1'b1, 0, 0);
`else
        run_op("wrap_store_half", 1'b1, 2'b01, 1'b0, 8'hFF, 32'h0000A1B2, '0, 1'b0, 0, 0);
        n_cmp++;
        if (mem[255] !== 8'hA1 || mem[0] !== 8'hB2) begin
            n_err++;
            $display("FAIL wrap_store_mem got %h,%h want a1,b2", mem[255], mem[0]);
        end
        run_op("mis_load_word", 1'b0, 2'b10, 1'b0, 8'h05, '0, 32'hADBEEF22, 1'b0, 0, 0);
`endif
    endtask

    task automatic test_busy_ignore();
        run_op("busy_ignore", 1'b0, 2'b10, 1'b0, 8'h08, '0, 32'h22222222, 1'b0, 0, 1);
        @(negedge clock);
        n_cmp++;
        if (busy !== 1'b0 || mem_we !== 1'b0 || mem[128] !== 8'h00) begin
            n_err++;
            $display("FAIL busy_ignore_after got busy=%b we=%b mem80=%h want 0,0,00", busy, mem_we, mem[128]);
        end
    endtask

    task automatic test_back_to_back();
        run_op("b2b_store", 1'b1, 2'b01, 1'b0, 8'h50, 32'h00001234, '0, 1'b0, 1, 0);
        run_op("b2b_load", 1'b0, 2'b01, 1'b0, 8'h50, '0, 32'h00001234, 1'b0, 0, 0);
    endtask

    task automatic test_reset_abort();
        run_op("pre_fill", 1'b1, 2'b10, 1'b0, 8'h40, 32'h5A5A5A5A, '0, 1'b0, 0, 0);
        req = 1'b1; write = 1'b1; size = 2'b10; addr = 8'h40; wdata = 32'h11223344;
        @(negedge clock);
        req = 1'b0;
        @(negedge clock);
        n_cmp++;
        if (mem_we !== 1'b1 || mem_addr !== 8'h41) begin
            n_err++;
            $display("FAIL abort_cycle1 got we=%b addr=%h want 1,41", mem_we, mem_addr);
        end
        reset = 1'b1;
        rdata_exp = 32'h0;
        @(negedge clock);
        n_cmp++;
        if (mem_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || rdata !== rdata_exp) begin
            n_err++;
            $display("FAIL abort_reset got we=%b busy=%b done=%b rdata=%h want 0,0,0,0", mem_we, busy, done, rdata);
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            n_cmp++;
            if (done !== 1'b0 || mem_we !== 1'b0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL abort_after%0d got done=%b we=%b busy=%b want 0,0,0", i, done, mem_we, busy);
            end
        end
        n_cmp++;
        if ({mem[64], mem[65], mem[66], mem[67]} !== 32'h11225A5A) begin
            n_err++;
            $display("FAIL abort_mem got %h%h%h%h want 11225a5a", mem[64], mem[65], mem[66], mem[67]);
        end
    endtask

    initial begin
        test_reset();
        test_store_word();
        test_load_word();
        test_load_byte_ext();
        test_load_half_word3();
        test_misaligned();
        test_busy_ignore();
        test_back_to_back();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no finish want finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule
